// File: rtl/epidemic_noc_pkg.sv
// Shared definitions for the epidemic-routing grid NoC: flit geometry and link sides.
package epidemic_noc_pkg;

    localparam int NOC_DATA_W = 32;
    localparam int NOC_ID_W   = 8;

    // The packet ID occupies the low bits of every flit.
    localparam int ID_LSB = 0;
    localparam int ID_MSB = NOC_ID_W - 1;

    typedef enum logic [1:0] {
        SIDE_L = 2'd0,
        SIDE_R = 2'd1,
        SIDE_T = 2'd2,
        SIDE_B = 2'd3
    } side_e;

endpackage

// File: rtl/epi_sync_fifo.sv
// DEPTH x DATA_W synchronous FIFO with full/empty/count; pushes when full and pops when empty are ignored.
module epi_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/epidemic_rx_port.sv
// Inbound link port: buffers flits and drops packet copies whose ID was seen recently.
// Define EPI_RX_STATS_EN to add the o_dup_cnt saturating duplicate counter port.
module epidemic_rx_port
    import epidemic_noc_pkg::*;
#(
    parameter int DATA_W = epidemic_noc_pkg::NOC_DATA_W,
    parameter int ID_W   = epidemic_noc_pkg::NOC_ID_W,
    parameter int DEPTH  = 4,
    parameter int SEEN   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready
`ifdef EPI_RX_STATS_EN
   ,output logic [15:0]       o_dup_cnt
`endif
);

    localparam int SW = $clog2(SEEN);

    logic              fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic              accept, hit, fifo_push, fifo_pop;
    logic [ID_W-1:0]   rx_id;

    logic [ID_W-1:0]   seen_id_q [SEEN];
    logic [SEEN-1:0]   seen_vld_q, seen_vld_d;
    logic [SW-1:0]     ins_ptr_q, ins_ptr_d;

    assign rx_id     = i_data[ID_LSB +: ID_W];
    assign o_ready   = rstn && !fifo_full;
    assign o_valid   = !fifo_empty;
    assign accept    = i_valid && o_ready;
    assign fifo_push = accept && !hit;
    assign fifo_pop  = o_valid && i_ready;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < SEEN; i++) begin
            if (seen_vld_q[i] && (seen_id_q[i] == rx_id)) hit = 1'b1;
        end
    end

    // Oldest-first replacement: the insert pointer simply rotates over the table.
    always_comb begin
        seen_vld_d = seen_vld_q;
        ins_ptr_d  = ins_ptr_q;
        if (fifo_push) begin
            seen_vld_d[ins_ptr_q] = 1'b1;
            ins_ptr_d             = ins_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            seen_vld_q <= '0;
            ins_ptr_q  <= '0;
        end else begin
            seen_vld_q <= seen_vld_d;
            ins_ptr_q  <= ins_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) seen_id_q[ins_ptr_q] <= rx_id;
    end

`ifdef EPI_RX_STATS_EN
    logic [15:0] dup_cnt_q, dup_cnt_d;

    always_comb begin
        dup_cnt_d = dup_cnt_q;
        if (accept && hit && (dup_cnt_q != 16'hFFFF)) dup_cnt_d = dup_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) dup_cnt_q <= '0;
        else       dup_cnt_q <= dup_cnt_d;
    end

    assign o_dup_cnt = dup_cnt_q;
`endif

    epi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .wdata (i_data),
        .pop   (fifo_pop),
        .rdata (o_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy is implied by full/empty at this level; count is kept for debug visibility.
    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule
